// File: rtl/mbe_mac_seq.sv
// Sequencer/accumulator for a shared 8x8 signed Booth multiplier (dot product).
// Define MBE_MAC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mbe_mac_seq #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       in_a,
  input  logic signed [7:0]       in_b,
  output logic signed [7:0]       mul_a,
  output logic signed [7:0]       mul_b,
  input  logic signed [15:0]      mul_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic                    out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]        cnt;
  logic                    pv;
  logic                    ovf;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic                    sum_ovf;
  logic                    accept;
  logic                    go;

`ifdef MBE_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN =
    {1'b1, {(ACC_W-1){1'b0}}};
`endif

  assign in_ready  = (state == RUN);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  assign accept = in_valid & in_ready;
  assign go     = (state == IDLE) & start;

  assign addend  = ACC_W'(mul_p);
  assign sum     = acc + addend;
  assign sum_ovf = (acc[ACC_W-1] == addend[ACC_W-1])
                 & (sum[ACC_W-1] != acc[ACC_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (accept && cnt == CNT_W'(1)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: state_nx = DONE;
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // product stage: pv marks that mul_p holds a pair accepted last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a <= '0;
      mul_b <= '0;
      pv    <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      pv <= accept;
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
        cnt   <= cnt - CNT_W'(1);
      end
      if (go) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= len;
      end else if (pv) begin
`ifdef MBE_MAC_SAT_EN
        if (sum_ovf) begin
          acc <= acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
          acc <= sum;
        end
`else
        acc <= sum;
`endif
        if (sum_ovf) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbe_mac_seq.sv
// Directed bench for mbe_mac_seq: default 24-bit and narrow 16-bit
// accumulator instances driven in lockstep.
module tb_mbe_mac_seq;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        len;
  logic              in_valid;
  logic signed [7:0] in_a;
  logic signed [7:0] in_b;
  logic              out_ready;

  logic               busy, in_ready, out_valid, out_ovf;
  logic signed [7:0]  mul_a, mul_b;
  logic signed [15:0] mul_p;
  logic signed [23:0] out_acc;

  logic               busy16, in_ready16, out_valid16, out_ovf16;
  logic signed [7:0]  mul_a16, mul_b16;
  logic signed [15:0] mul_p16;
  logic signed [15:0] out_acc16;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mul_p   = mul_a * mul_b;
  assign mul_p16 = mul_a16 * mul_b16;

  mbe_mac_seq #(.ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf)
  );

  mbe_mac_seq #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .busy(busy16), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a16), .mul_b(mul_b16),
    .mul_p(mul_p16), .out_valid(out_valid16), .out_ready(out_ready),
    .out_acc(out_acc16), .out_ovf(out_ovf16)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic signed [7:0] a,
                      input logic signed [7:0] b);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    chk("in_ready_wait", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_hold(input int n, input int ea, input int eb);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("bubble_mul_a", int'(mul_a), ea);
      chk("bubble_mul_b", int'(mul_b), eb);
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20; k++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    chk("out_valid_wait", int'(out_valid), 1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("busy_after_hs", int'(busy), 0);
  endtask

  task automatic kick(input int n);
    start = 1'b1;
    len = 8'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_acc", int'(out_acc), 0);
    chk("rst_mul_a", int'(mul_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // job 1: back-to-back, exact latency
    chk("t1_busy_pre", int'(busy), 0);
    kick(3);
    chk("t1_busy", int'(busy), 1);
    chk("t1_in_ready", int'(in_ready), 1);
    send(3, 4);
    send(-5, 6);
    send(-128, -128);
    chk("t1_valid_c1", int'(out_valid), 0);
    chk("t1_busy_c1", int'(busy), 1);
    @(negedge clk);
    chk("t1_valid_c2", int'(out_valid), 1);
    chk("t1_acc", int'(out_acc), 16366);
    chk("t1_acc16", int'(out_acc16), 16366);
    chk("t1_ovf", int'(out_ovf), 0);
    take();

    // job 2: bubbles between pairs
    kick(4);
    send(7, -1);
    idle_hold(2, 7, -1);
    send(2, 2);
    idle_hold(3, 2, 2);
    send(-1, -1);
    idle_hold(1, -1, -1);
    send(127, 127);
    wait_done();
    chk("t2_acc", int'(out_acc), 16127);
    chk("t2_ovf", int'(out_ovf), 0);
    take();

    // job 3: len 0
    kick(0);
    chk("t3_valid", int'(out_valid), 1);
    chk("t3_acc", int'(out_acc), 0);
    chk("t3_in_ready", int'(in_ready), 0);
    take();

    // job 4: result stall with start pulses in DONE
    kick(1);
    send(5, 5);
    wait_done();
    start = 1'b1;
    len = 8'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_valid", int'(out_valid), 1);
      chk("t4_hold_acc", int'(out_acc), 25);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk("t4_start_ign", int'(busy), 0);
    @(negedge clk);
    chk("t4_still_idle", int'(busy), 0);
    kick(2);
    send(1, 1);
    send(2, -3);
    wait_done();
    chk("t4_acc", int'(out_acc), -5);
    take();

    // job 5: reset mid-job, then a fresh job
    kick(5);
    send(10, 10);
    send(20, 20);
    in_valid = 1'b1;
    in_a = 8'sd3;
    in_b = 8'sd3;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_in_ready", int'(in_ready), 0);
    chk("t5_valid", int'(out_valid), 0);
    chk("t5_acc", int'(out_acc), 0);
    chk("t5_mul_a", int'(mul_a), 0);
    chk("t5_mul_b", int'(mul_b), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kick(1);
    send(-2, 3);
    wait_done();
    chk("t5_acc_new", int'(out_acc), -6);
    chk("t5_ovf_new", int'(out_ovf), 0);
    take();

    // job 6: overflow on the 16-bit accumulator
    kick(3);
    send(-128, -128);
    send(-128, -128);
    send(-128, -128);
    wait_done();
    chk("t6_acc24", int'(out_acc), 49152);
    chk("t6_ovf24", int'(out_ovf), 0);
    chk("t6_ovf16", int'(out_ovf16), 1);
`ifdef MBE_MAC_SAT_EN
    chk("t6_acc16", int'(out_acc16), 32767);
`else
    chk("t6_acc16", int'(out_acc16), -16384);
`endif
    take();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mbe_mac_seq.md
Name: mbe_mac_seq

Overview:
- Sequencer and accumulator controller for the shared 8x8 signed modified-Booth multiplier in the MAC datapath.
- Accepts a job of LEN operand pairs over a valid/ready stream and drives the multiplier's A/B inputs from registers.
- Accumulates the multiplier's combinational 16-bit product into a signed ACC_W-bit sum.
- Returns the dot product on a valid/ready result port. The multiplier is external: this block drives mul_a/mul_b and receives mul_p.

Parameters:
- ACC_W, 24: accumulator and result width in bits. Must be at least 16.
- CNT_W, 8: width of the job length field. Maximum LEN is 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; sampled only in IDLE.
- len  in  CNT_W  number of operand pairs, unsigned; sampled together with start.
- busy  out  1  high whenever state != IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid & in_ready.
- in_a  in  8  signed multiplicand.
- in_b  in  8  signed multiplier.
- mul_a  out  8  registered multiplicand to the multiplier.
- mul_b  out  8  registered multiplier operand to the multiplier.
- mul_p  in  16  signed product from the multiplier, combinational from mul_a/mul_b.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid & out_ready.
- out_acc  out  ACC_W  signed accumulated result.
- out_ovf  out  1  sticky signed-overflow flag for the job.

Behaviour:
- Reset: all outputs 0, state = IDLE, acc/cnt/pv = 0. Reset is asynchronous and active-low; asserting it mid-job aborts the job with no result produced.
- States: IDLE, RUN, DRAIN, DONE. in_ready = (state==RUN), a decode of registered state. out_valid = (state==DONE). out_acc is driven from the acc register.
- IDLE: on start, acc <= 0, ovf <= 0, cnt <= len. If len==0 go to DONE, otherwise go to RUN. With start low, stay in IDLE.
- RUN, on accept:
  - mul_a <= in_a, mul_b <= in_b, pv <= 1, cnt <= cnt-1.
  - If cnt==1, go to DRAIN.
  - With no accept, pv <= 0 and mul_a/mul_b hold their values.
- Accumulate: in any cycle with pv==1, acc <= acc + sign_extend(mul_p, ACC_W). This is a one-cycle product stage, so each pair's product enters acc on the edge after its accept.
- DRAIN: one cycle; adds the last product, pv <= 0, go to DONE.
- DONE: out_valid = 1. out_acc and out_ovf stay stable until out_valid & out_ready, then go to IDLE.
- Latency: if the final pair is accepted in cycle C, out_valid is high in cycle C+2. A job with len==0 has out_valid high in the cycle after start.
- Back-pressure and bubbles: in_valid low in RUN inserts bubbles; acc is unaffected by them. out_ready low holds DONE indefinitely.
- start outside IDLE is ignored, including in the same cycle as the DONE handshake. A new job may start, at the earliest, in the cycle after returning to IDLE.
- Overflow: signed overflow occurs when the addends have the same sign and the sum's sign differs. Any overflow sets ovf for the rest of the job. Without the optional feature, acc wraps modulo 2^ACC_W.
- The default ACC_W=24 with CNT_W=8 cannot overflow: 255*16384 < 2^23.

Optional Feature:
- MBE_MAC_SAT_EN defined: on overflow, acc saturates to 2^(ACC_W-1)-1 (positive overflow) or -2^(ACC_W-1) (negative overflow). ovf still sets, and later additions continue from the clamped value.
- MBE_MAC_SAT_EN undefined: two's-complement wrap, with the ovf flag only.

Test Plan:
- len=3; pairs (3,4), (-5,6), (-128,-128) back-to-back -> out_acc=16366, out_ovf=0, out_valid exactly 2 cycles after the 3rd accept; busy high from the cycle after start until the handshake.
- len=4; pairs (7,-1), (2,2), (-1,-1), (127,127) with 0-3 idle cycles of in_valid between pairs -> out_acc=16127; mul_a/mul_b hold during bubbles.
- len=0 start -> out_valid high the next cycle with out_acc=0; in_ready never asserted.
- Result stall: out_ready held low 5 cycles with start pulsed during DONE -> out_acc stable, start ignored; after the handshake, busy=0 and a new job runs normally.
- Reset: rst_n pulsed low after 2 of 5 pairs in RUN -> all outputs 0 immediately; the next job (len=1, (-2,3)) returns -6.
- Overflow (ACC_W=16): len=3, three pairs (-128,-128) -> out_acc=-16384 (wrapped) with out_ovf=1; with MBE_MAC_SAT_EN, out_acc=32767 with out_ovf=1.
